// File: rtl/corner_tracker_pkg.sv
// rtl/corner_tracker_pkg.sv - state encoding and default parameters for the corner tracker
package corner_tracker_pkg;

  localparam logic [1:0] ST_WAIT_SYNC = 2'd0;
  localparam logic [1:0] ST_ACCUM     = 2'd1;
  localparam logic [1:0] ST_COMMIT    = 2'd2;

  localparam int DEF_COORD_W    = 10;
  localparam int DEF_FRAME_W    = 640;
  localparam int DEF_FRAME_H    = 480;
  localparam int DEF_CNT_W      = 10;
  localparam int DEF_MIN_PIXELS = 16;

endpackage

// File: rtl/corner_tracker_if.sv
// rtl/corner_tracker_if.sv - pixel input stream and published-corner result bundle
interface corner_tracker_if #(
  parameter int COORD_W = 10
);

  logic               VGA_VS;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic               pixel_valid;

  logic [COORD_W-1:0] out_top_left_x;
  logic [COORD_W-1:0] out_top_left_y;
  logic [COORD_W-1:0] out_top_right_x;
  logic [COORD_W-1:0] out_top_right_y;
  logic [COORD_W-1:0] out_bot_left_x;
  logic [COORD_W-1:0] out_bot_left_y;
  logic [COORD_W-1:0] out_bot_right_x;
  logic [COORD_W-1:0] out_bot_right_y;
  logic               out_aligned;
  logic               out_valid;
  logic               out_empty;

  modport master (
    output VGA_VS, pixel_x, pixel_y, pixel_valid,
    input  out_top_left_x, out_top_left_y, out_top_right_x, out_top_right_y,
    input  out_bot_left_x, out_bot_left_y, out_bot_right_x, out_bot_right_y,
    input  out_aligned, out_valid, out_empty
  );

  modport slave (
    input  VGA_VS, pixel_x, pixel_y, pixel_valid,
    output out_top_left_x, out_top_left_y, out_top_right_x, out_top_right_y,
    output out_bot_left_x, out_bot_left_y, out_bot_right_x, out_bot_right_y,
    output out_aligned, out_valid, out_empty
  );

endinterface

// File: rtl/corner_tracker_extreme_track.sv
// rtl/corner_tracker_extreme_track.sv - one min-or-max tracker with last-wins point and saturating tie count
module extreme_track #(
  parameter int W      = 10,
  parameter int CNT_W  = 10,
  parameter bit IS_MAX = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [W-1:0]     init_val,
  input  logic [W-1:0]     val,
  input  logic [W-1:0]     px,
  input  logic [W-1:0]     py,
  output logic [W-1:0]     ext,
  output logic [W-1:0]     pt_x,
  output logic [W-1:0]     pt_y,
  output logic [CNT_W-1:0] tie
);

  localparam logic [CNT_W-1:0] TIE_MAX = '1;

  logic [W-1:0]     ext_q, ext_d;
  logic [W-1:0]     pt_x_q, pt_x_d;
  logic [W-1:0]     pt_y_q, pt_y_d;
  logic [CNT_W-1:0] tie_q, tie_d;
  logic             better;
  logic             equal;

  always_comb begin
    better = IS_MAX ? (val > ext_q) : (val < ext_q);
    equal  = (val == ext_q);
    ext_d  = ext_q;
    pt_x_d = pt_x_q;
    pt_y_d = pt_y_q;
    tie_d  = tie_q;
    if (clear) begin
      ext_d  = init_val;
      pt_x_d = '0;
      pt_y_d = '0;
      tie_d  = '0;
    end else if (en) begin
      if (better) begin
        ext_d  = val;
        pt_x_d = px;
        pt_y_d = py;
        tie_d  = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (equal) begin
        pt_x_d = px;
        pt_y_d = py;
        if (tie_q != TIE_MAX) begin
          tie_d = tie_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ext_q  <= init_val;
      pt_x_q <= '0;
      pt_y_q <= '0;
      tie_q  <= '0;
    end else begin
      ext_q  <= ext_d;
      pt_x_q <= pt_x_d;
      pt_y_q <= pt_y_d;
      tie_q  <= tie_d;
    end
  end

  assign ext  = ext_q;
  assign pt_x = pt_x_q;
  assign pt_y = pt_y_q;
  assign tie  = tie_q;

endmodule

// File: rtl/corner_tracker.sv
// rtl/corner_tracker.sv - per-frame bounding extremes with aligned/rotated corner publication on VS fall
module corner_tracker
  import corner_tracker_pkg::*;
#(
  parameter int COORD_W    = DEF_COORD_W,
  parameter int FRAME_W    = DEF_FRAME_W,
  parameter int FRAME_H    = DEF_FRAME_H,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MIN_PIXELS = DEF_MIN_PIXELS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] threshold,
  corner_tracker_if.slave  bus
);

  localparam int                 PC_W   = $clog2(MIN_PIXELS + 1);
  localparam logic [PC_W-1:0]    PC_MIN = PC_W'(MIN_PIXELS);
  localparam logic [COORD_W:0]   X_LIM  = (COORD_W+1)'(FRAME_W);
  localparam logic [COORD_W:0]   Y_LIM  = (COORD_W+1)'(FRAME_H);
  localparam logic [COORD_W-1:0] X_INIT = COORD_W'(FRAME_W - 1);
  localparam logic [COORD_W-1:0] Y_INIT = COORD_W'(FRAME_H - 1);
  localparam logic [COORD_W-1:0] ZERO   = '0;

  logic             vs_prev_q, vs_prev_d;
  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  cnt_q, cnt_d;
  logic             fall;
  logic             accept;
  logic             commit;

  logic [COORD_W-1:0] x_min, x_min_px, x_min_py;
  logic [COORD_W-1:0] x_max, x_max_px, x_max_py;
  logic [COORD_W-1:0] y_min, y_min_px, y_min_py;
  logic [COORD_W-1:0] y_max, y_max_px, y_max_py;
  logic [CNT_W-1:0]   x_min_tie, x_max_tie, y_min_tie, y_max_tie;

  logic [COORD_W-1:0] tl_x_q, tl_x_d, tl_y_q, tl_y_d;
  logic [COORD_W-1:0] tr_x_q, tr_x_d, tr_y_q, tr_y_d;
  logic [COORD_W-1:0] bl_x_q, bl_x_d, bl_y_q, bl_y_d;
  logic [COORD_W-1:0] br_x_q, br_x_d, br_y_q, br_y_d;
  logic               aligned_q, aligned_d;
  logic               valid_q, valid_d;
  logic               empty_q, empty_d;
  logic               aligned_now;

  // Pixels in the boundary cycle belong to neither frame, so fall gates acceptance.
  always_comb begin
    vs_prev_d = bus.VGA_VS;
    fall      = vs_prev_q & ~bus.VGA_VS;
    commit    = (state_q == ST_COMMIT);
    accept    = (state_q == ST_ACCUM) && !fall && bus.pixel_valid &&
                ({1'b0, bus.pixel_x} < X_LIM) && ({1'b0, bus.pixel_y} < Y_LIM);
    state_d   = state_q;
    case (state_q)
      ST_WAIT_SYNC: if (fall) state_d = ST_ACCUM;
      ST_ACCUM:     if (fall) state_d = ST_COMMIT;
      ST_COMMIT:    state_d = ST_ACCUM;
      default:      state_d = ST_WAIT_SYNC;
    endcase
    cnt_d = cnt_q;
    if (commit) begin
      cnt_d = '0;
    end else if (accept && cnt_q != PC_MIN) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  extreme_track #(.W(COORD_W), .CNT_W(CNT_W), .IS_MAX(1'b0)) u_x_min (
    .clk(clk), .reset(reset), .clear(commit), .en(accept), .init_val(X_INIT),
    .val(bus.pixel_x), .px(bus.pixel_x), .py(bus.pixel_y),
    .ext(x_min), .pt_x(x_min_px), .pt_y(x_min_py), .tie(x_min_tie)
  );

  extreme_track #(.W(COORD_W), .CNT_W(CNT_W), .IS_MAX(1'b1)) u_x_max (
    .clk(clk), .reset(reset), .clear(commit), .en(accept), .init_val(ZERO),
    .val(bus.pixel_x), .px(bus.pixel_x), .py(bus.pixel_y),
    .ext(x_max), .pt_x(x_max_px), .pt_y(x_max_py), .tie(x_max_tie)
  );

  extreme_track #(.W(COORD_W), .CNT_W(CNT_W), .IS_MAX(1'b0)) u_y_min (
    .clk(clk), .reset(reset), .clear(commit), .en(accept), .init_val(Y_INIT),
    .val(bus.pixel_y), .px(bus.pixel_x), .py(bus.pixel_y),
    .ext(y_min), .pt_x(y_min_px), .pt_y(y_min_py), .tie(y_min_tie)
  );

  extreme_track #(.W(COORD_W), .CNT_W(CNT_W), .IS_MAX(1'b1)) u_y_max (
    .clk(clk), .reset(reset), .clear(commit), .en(accept), .init_val(ZERO),
    .val(bus.pixel_y), .px(bus.pixel_x), .py(bus.pixel_y),
    .ext(y_max), .pt_x(y_max_px), .pt_y(y_max_py), .tie(y_max_tie)
  );

  // A long run of equal extremes means an edge parallel to an axis.
  always_comb begin
    aligned_now = (x_min_tie > threshold) || (x_max_tie > threshold) ||
                  (y_min_tie > threshold) || (y_max_tie > threshold);
    tl_x_d    = tl_x_q;
    tl_y_d    = tl_y_q;
    tr_x_d    = tr_x_q;
    tr_y_d    = tr_y_q;
    bl_x_d    = bl_x_q;
    bl_y_d    = bl_y_q;
    br_x_d    = br_x_q;
    br_y_d    = br_y_q;
    aligned_d = aligned_q;
    empty_d   = empty_q;
    valid_d   = 1'b0;
    if (commit) begin
      valid_d = 1'b1;
      if (cnt_q >= PC_MIN) begin
        empty_d   = 1'b0;
        aligned_d = aligned_now;
        if (aligned_now) begin
          tl_x_d = x_min;    tl_y_d = y_min;
          tr_x_d = x_max;    tr_y_d = y_min;
          bl_x_d = x_min;    bl_y_d = y_max;
          br_x_d = x_max;    br_y_d = y_max;
        end else begin
          tl_x_d = x_min_px; tl_y_d = x_min_py;
          tr_x_d = y_min_px; tr_y_d = y_min_py;
          br_x_d = x_max_px; br_y_d = x_max_py;
          bl_x_d = y_max_px; bl_y_d = y_max_py;
        end
      end else begin
        empty_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vs_prev_q <= 1'b0;
      state_q   <= ST_WAIT_SYNC;
      cnt_q     <= '0;
      tl_x_q    <= '0;
      tl_y_q    <= '0;
      tr_x_q    <= '0;
      tr_y_q    <= '0;
      bl_x_q    <= '0;
      bl_y_q    <= '0;
      br_x_q    <= '0;
      br_y_q    <= '0;
      aligned_q <= 1'b0;
      valid_q   <= 1'b0;
      empty_q   <= 1'b0;
    end else begin
      vs_prev_q <= vs_prev_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tl_x_q    <= tl_x_d;
      tl_y_q    <= tl_y_d;
      tr_x_q    <= tr_x_d;
      tr_y_q    <= tr_y_d;
      bl_x_q    <= bl_x_d;
      bl_y_q    <= bl_y_d;
      br_x_q    <= br_x_d;
      br_y_q    <= br_y_d;
      aligned_q <= aligned_d;
      valid_q   <= valid_d;
      empty_q   <= empty_d;
    end
  end

  assign bus.out_top_left_x  = tl_x_q;
  assign bus.out_top_left_y  = tl_y_q;
  assign bus.out_top_right_x = tr_x_q;
  assign bus.out_top_right_y = tr_y_q;
  assign bus.out_bot_left_x  = bl_x_q;
  assign bus.out_bot_left_y  = bl_y_q;
  assign bus.out_bot_right_x = br_x_q;
  assign bus.out_bot_right_y = br_y_q;
  assign bus.out_aligned     = aligned_q;
  assign bus.out_valid       = valid_q;
  assign bus.out_empty       = empty_q;

endmodule

// File: tb/tb_corner_tracker.sv
// tb/tb_corner_tracker.sv - frame-table and hand-sequence checks of corner_tracker
module tb_corner_tracker;

  typedef struct {
    int kind;
    int thr;
    int aligned;
    int empty;
    int c[8];
  } vec_t;

  logic       clk;
  logic       reset;
  logic [3:0] threshold;
  int         checks;
  int         errors;
  vec_t       tbl[6];
  vec_t       sq_small;

  corner_tracker_if #(.COORD_W(10)) vif ();

  corner_tracker #(
    .COORD_W(10), .FRAME_W(640), .FRAME_H(480), .CNT_W(4), .MIN_PIXELS(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .threshold(threshold),
    .bus(vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int kind, thr, al, em,
                              input int tlx, tly, trx, tr_y, blx, bly, brx, bry);
    vec_t v;
    v.kind = kind; v.thr = thr; v.aligned = al; v.empty = em;
    v.c[0] = tlx; v.c[1] = tly; v.c[2] = trx; v.c[3] = tr_y;
    v.c[4] = blx; v.c[5] = bly; v.c[6] = brx; v.c[7] = bry;
    return v;
  endfunction

  function automatic int out_coord(input int k);
    case (k)
      0: return int'(vif.out_top_left_x);
      1: return int'(vif.out_top_left_y);
      2: return int'(vif.out_top_right_x);
      3: return int'(vif.out_top_right_y);
      4: return int'(vif.out_bot_left_x);
      5: return int'(vif.out_bot_left_y);
      6: return int'(vif.out_bot_right_x);
      default: return int'(vif.out_bot_right_y);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic px(input int x, input int y);
    @(posedge clk); #1;
    vif.VGA_VS      = 1'b1;
    vif.pixel_x     = 10'(x);
    vif.pixel_y     = 10'(y);
    vif.pixel_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      vif.pixel_valid = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    for (int k = 0; k < 8; k++) chk($sformatf("%s_corner%0d", tag, k), out_coord(k), v.c[k]);
    chk({tag, "_aligned"}, int'(vif.out_aligned), v.aligned);
    chk({tag, "_empty"}, int'(vif.out_empty), v.empty);
  endtask

  // Falling edge with an optional pixel in both the edge cycle and the COMMIT cycle.
  task automatic fall_check(input string tag, input vec_t v, input bit coin, input int cx, input int cy);
    @(posedge clk); #1;
    vif.VGA_VS = 1'b0; vif.pixel_valid = coin; vif.pixel_x = 10'(cx); vif.pixel_y = 10'(cy);
    @(negedge clk); chk({tag, "_valid_edge"}, int'(vif.out_valid), 0);
    @(posedge clk); #1;
    vif.VGA_VS = 1'b1;
    @(negedge clk); chk({tag, "_valid_commit"}, int'(vif.out_valid), 0);
    @(posedge clk); #1;
    vif.pixel_valid = 1'b0;
    @(negedge clk); chk({tag, "_valid_pulse"}, int'(vif.out_valid), 1);
    check_outputs(tag, v);
    @(posedge clk); #1;
    @(negedge clk); chk({tag, "_valid_after"}, int'(vif.out_valid), 0);
  endtask

  task automatic fall_none(input string tag);
    @(posedge clk); #1;
    vif.VGA_VS = 1'b0; vif.pixel_valid = 1'b0;
    @(posedge clk); #1;
    vif.VGA_VS = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk($sformatf("%s_no_valid%0d", tag, i), int'(vif.out_valid), 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input int kind);
    case (kind)
      0: begin
        for (int t = 100; t <= 200; t++) begin px(t, 50); px(t, 150); end
        for (int t = 51; t <= 149; t++) begin px(100, t); px(200, t); end
      end
      1: begin
        for (int i = 0; i < 20; i++) px(250 + i * 5, 180 + i);
        px(300, 100); px(400, 200); px(300, 300); px(200, 200);
      end
      2: for (int i = 0; i < 5; i++) px(30 + i, 40 + i);
      3: begin
        px(640, 10); px(20, 480); px(639, 479);
        for (int i = 0; i < 15; i++) px(10 + i, 20 + i);
      end
      default: for (int i = 0; i < 20; i++) px(50, i);
    endcase
    idle(2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tbl[0] = mk(0, 3, 1, 0, 100, 50, 200, 50, 100, 150, 200, 150);
    tbl[1] = mk(1, 3, 0, 0, 200, 200, 300, 100, 300, 300, 400, 200);
    tbl[2] = mk(2, 3, 0, 1, 200, 200, 300, 100, 300, 300, 400, 200);
    tbl[3] = mk(3, 3, 0, 0, 10, 20, 10, 20, 639, 479, 639, 479);
    tbl[4] = mk(4, 15, 0, 0, 50, 19, 50, 0, 50, 19, 50, 19);
    tbl[5] = mk(5, 14, 1, 0, 50, 0, 50, 0, 50, 19, 50, 19);
    sq_small = mk(6, 3, 1, 0, 10, 10, 20, 10, 10, 20, 20, 20);

    reset = 1'b0; threshold = 4'd3;
    vif.VGA_VS = 1'b1; vif.pixel_x = '0; vif.pixel_y = '0; vif.pixel_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("reset_valid", int'(vif.out_valid), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 5; i++) px(i, i);
    idle(1);
    fall_none("first_sync");

    for (int i = 0; i < 6; i++) begin
      threshold = 4'(tbl[i].thr);
      send_frame(tbl[i].kind);
      fall_check($sformatf("frame%0d", i), tbl[i], tbl[i].kind == 3, 0, 0);
    end

    for (int i = 0; i < 3; i++) px(5, 5);
    @(posedge clk); #1;
    reset = 1'b0; vif.pixel_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_outputs("midreset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("midreset_valid", int'(vif.out_valid), 0);
    threshold = 4'd3;
    for (int i = 0; i < 20; i++) px(0, 0);
    idle(1);
    fall_none("midreset_sync");
    for (int i = 0; i < 4; i++) begin
      px(10, 10); px(20, 10); px(10, 20); px(20, 20);
    end
    idle(2);
    fall_check("midreset_frame", sq_small, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
